// File: rtl/wload_pkg.sv
// wload_pkg: shared constants and FSM state type for the weight loader
//   BANKS/DEPTH/AW/DW : default geometry (16 banks x 9 taps, 4-bit address, 8-bit weights)
//   LOAD_BEATS        : beats in one complete kernel set
//   wload_state_t     : IDLE / LOAD / DONE
package wload_pkg;
   localparam int BANKS      = 16;
   localparam int DEPTH      = 9;
   localparam int AW         = 4;
   localparam int DW         = 8;
   localparam int LOAD_BEATS = BANKS * DEPTH;
   typedef enum logic [1:0] {IDLE, LOAD, DONE} wload_state_t;
endpackage

// File: rtl/count_wrap.sv
// count_wrap: enabled up-counter that wraps to zero after a programmable max
//   clk, xrst : clock, async active-low reset
//   clr_i     : synchronous clear (wins over en_i)
//   en_i      : advance one step
//   max_i     : last count value before wrapping
//   cnt_o     : current count
//   max_o     : count equals max_i (cascade into the next counter's enable)
module count_wrap #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         xrst,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] max_i,
   output logic [W-1:0] cnt_o,
   output logic         max_o
);
   logic [W-1:0] cnt_q, cnt_d;
   assign max_o = cnt_q == max_i;
   assign cnt_o = cnt_q;
   always_comb cnt_d = clr_i ? '0 : en_i ? (max_o ? '0 : cnt_q + W'(1)) : cnt_q;
   always_ff @(posedge clk or negedge xrst)
      if (!xrst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
endmodule

// File: rtl/weight_loader.sv
// weight_loader: distributes a host weight stream bank-fastest over BANKS weight banks
//   clk, xrst         : clock, async active-low reset
//   start             : begin a load (ignored while loading)
//   s_valid/s_data    : host weight stream, s_ready = loader in LOAD
//   we/waddr/wdata    : registered bank write port, one-hot we, shared address/data
//   busy / finish     : in LOAD / in DONE
//   checksum          : running 16-bit sum of accepted weights (WLOAD_CHECKSUM_EN only)
module weight_loader
   import wload_pkg::*;
#(
   parameter int BANKS = wload_pkg::BANKS,
   parameter int DEPTH = wload_pkg::DEPTH,
   parameter int AW    = wload_pkg::AW,
   parameter int DW    = wload_pkg::DW
) (
   input  logic             clk,
   input  logic             xrst,
   input  logic             start,
   input  logic             s_valid,
   input  logic [DW-1:0]    s_data,
   output logic             s_ready,
   output logic [BANKS-1:0] we,
   output logic [AW-1:0]    waddr,
   output logic [DW-1:0]    wdata,
   output logic             busy,
   output logic             finish
`ifdef WLOAD_CHECKSUM_EN
   ,
   output logic [15:0]      checksum
`endif
);
   localparam int BW = $clog2(BANKS);
   wload_state_t state_q, state_d;
   logic             acc, enter, bank_max, tap_max;
   logic [BW-1:0]    bank;
   logic [AW-1:0]    tap;
   logic [BANKS-1:0] we_q, we_d;
   logic [AW-1:0]    waddr_q, waddr_d;
   logic [DW-1:0]    wdata_q, wdata_d;
   assign acc   = s_valid && state_q == LOAD;
   // counters and checksum clear whenever a start actually opens a load
   assign enter = start && state_q != LOAD;
   count_wrap #(.W(BW)) u_bank (
      .clk   (clk),
      .xrst  (xrst),
      .clr_i (enter),
      .en_i  (acc),
      .max_i (BW'(BANKS - 1)),
      .cnt_o (bank),
      .max_o (bank_max)
   );
   count_wrap #(.W(AW)) u_tap (
      .clk   (clk),
      .xrst  (xrst),
      .clr_i (enter),
      .en_i  (acc && bank_max),
      .max_i (AW'(DEPTH - 1)),
      .cnt_o (tap),
      .max_o (tap_max)
   );
   always_comb begin
      state_d = enter ? LOAD : (acc && bank_max && tap_max) ? DONE : state_q;
      we_d    = acc ? BANKS'(1) << bank : '0;
      waddr_d = acc ? tap : waddr_q;
      wdata_d = acc ? s_data : wdata_q;
   end
   always_ff @(posedge clk or negedge xrst)
      if (!xrst) begin
         state_q <= IDLE;
         we_q    <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   assign s_ready = state_q == LOAD;
   assign busy    = state_q == LOAD;
   assign finish  = state_q == DONE;
   assign we      = we_q;
   assign waddr   = waddr_q;
   assign wdata   = wdata_q;
`ifdef WLOAD_CHECKSUM_EN
   logic [15:0] sum_q, sum_d;
   always_comb sum_d = enter ? '0 : acc ? sum_q + {{(16-DW){s_data[DW-1]}}, s_data} : sum_q;
   always_ff @(posedge clk or negedge xrst)
      if (!xrst) sum_q <= '0;
      else       sum_q <= sum_d;
   assign checksum = sum_q;
`endif
endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: scoreboard bench for weight_loader (checksum checks with WLOAD_CHECKSUM_EN)
module tb_weight_loader;
   logic        clk = 0;
   logic        xrst = 0;
   logic        start = 0;
   logic        s_valid = 0;
   logic [7:0]  s_data = 0;
   logic        s_ready, busy, finish;
   logic [15:0] we;
   logic [3:0]  waddr;
   logic [7:0]  wdata;
`ifdef WLOAD_CHECKSUM_EN
   logic [15:0] checksum;
`endif
   typedef struct packed {
      logic [15:0] we;
      logic [3:0]  addr;
      logic [7:0]  data;
   } wr_t;
   wr_t  q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   m_state = 0;
   int   m_n = 0;
   logic [3:0]  m_waddr = 0;
   logic [7:0]  m_wdata = 0;
   logic [15:0] m_sum = 0;

   weight_loader dut (
      .clk      (clk),
      .xrst     (xrst),
      .start    (start),
      .s_valid  (s_valid),
      .s_data   (s_data),
      .s_ready  (s_ready),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .busy     (busy),
      .finish   (finish)
`ifdef WLOAD_CHECKSUM_EN
      ,
      .checksum (checksum)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      wr_t e;
      logic [15:0] exp_we;
      exp_we = 0;
      if (q.size() > 0) begin
         e = q.pop_front();
         exp_we = e.we;
         m_waddr = e.addr;
         m_wdata = e.data;
      end
      chk("s_ready", s_ready, m_state == 1);
      chk("busy", busy, m_state == 1);
      chk("finish", finish, m_state == 2);
      chk("we", we, exp_we);
      chk("waddr", waddr, m_waddr);
      chk("wdata", wdata, m_wdata);
`ifdef WLOAD_CHECKSUM_EN
      chk("checksum", checksum, m_sum);
`endif
   endtask

   // one clock: check the current cycle, drive the next, advance the model
   task automatic step(input logic st, input logic v, input logic [7:0] d);
      wr_t e;
      @(negedge clk);
      check_outputs();
      start = st;
      s_valid = v;
      s_data = d;
      if (xrst && v && m_state == 1) begin
         e.we = 16'(1) << (m_n % 16);
         e.addr = 4'(m_n / 16);
         e.data = d;
         q.push_back(e);
         m_sum = m_sum + {{8{d[7]}}, d};
         m_n++;
         if (m_n == 144) m_state = 2;
      end else if (xrst && st && m_state != 1) begin
         m_state = 1;
         m_n = 0;
         m_sum = 0;
      end
   endtask

   task automatic do_reset();
      xrst = 0;
      #1;
      m_state = 0;
      q.delete();
      m_waddr = 0;
      m_wdata = 0;
      m_sum = 0;
      chk("rst_we", we, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_ready", s_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_finish", finish, 0);
   endtask

   initial begin
      do_reset();
      repeat (2) step(0, 0, 0);
      xrst = 1;
      // IDLE with s_valid asserted: nothing accepted
      for (int i = 0; i < 20; i++) step(0, 1, 8'($urandom));
      // full back-to-back load
      step(1, 0, 0);
      for (int n = 0; n < 144; n++) step(0, 1, 8'(n % 256 - 128));
      step(0, 0, 0);
      chk("full_finish", finish, 1);
      chk("full_busy", busy, 0);
      repeat (3) step(0, 1, 8'h55);
      // restart from DONE, gapped source, start pulsed at beat 50
      step(1, 0, 0);
      for (int n = 0; n < 144; n++) begin
         step(n == 50, 1, 8'($urandom));
         step(0, 0, 8'($urandom));
      end
      step(0, 0, 0);
      chk("gap_finish", finish, 1);
      // reset in the middle of a load
      step(1, 0, 0);
      for (int n = 0; n < 70; n++) step(0, 1, 8'($urandom));
      @(negedge clk);
      check_outputs();
      s_valid = 1;
      do_reset();
      repeat (3) step(0, 1, 8'h11);
      xrst = 1;
      repeat (5) step(0, 1, 8'h22);
      // reload with all -1, then all 0x7F
      step(1, 0, 0);
      for (int n = 0; n < 144; n++) step(0, 1, 8'hFF);
      step(0, 0, 0);
      chk("m1_finish", finish, 1);
`ifdef WLOAD_CHECKSUM_EN
      chk("m1_checksum", checksum, 16'hFF70);
`endif
      step(1, 0, 0);
      step(0, 0, 0);
      chk("restart_finish", finish, 0);
      for (int n = 0; n < 144; n++) step(0, 1, 8'h7F);
      step(0, 0, 0);
      chk("p7f_finish", finish, 1);
`ifdef WLOAD_CHECKSUM_EN
      chk("p7f_checksum", checksum, 16'h4770);
`endif
      step(0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
